// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift step per clock,
// with the result saturating to all nines when the input exceeds the digit range.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SCR_W = 4 * (DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, done_q;

  logic [SCR_W-1:0]       adj;
  logic [SCR_W+BIN_W-1:0] shifted;

  // Next-state, datapath step and result load
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    adj     = scr_q;

    for (int i = 0; i < int'(DIGITS + 1); i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[BIN_W +: SCR_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // A non-zero extra top digit means the value exceeded the output range
          ovf_d   = |scr_d[SCR_W-1 -: 4];
          bcd_d   = ovf_d ? {DIGITS{4'h9}} : scr_d[BCD_W-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        done_cnt++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got bcd=%h with no result expected", bcd);
        end else begin
          e = q.pop_front();
          check("result_bcd", 32'(bcd), 32'(e.bcd));
          check("result_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
  endtask

  task automatic conv(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    push_exp(eb, eo);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int busy_cycles;
    int d0;
    int t1, t2, t3;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    check("reset_bcd",  32'(bcd),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // V1: latency and busy duration
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    push_exp(16'h1234, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cycles++;
    end
    check("v1_busy_cycles", 32'(busy_cycles), 32'd14);
    check("v1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("v1_done_low", 32'(done), 32'd0);
    check("v1_bcd_held", 32'(bcd), 32'h1234);

    // V2 / V3: range boundaries
    conv(14'd0,     16'h0000, 1'b0);
    conv(14'd9999,  16'h9999, 1'b0);
    conv(14'd10000, 16'h9999, 1'b1);
    conv(14'd16383, 16'h9999, 1'b1);

    // V4: re-pulse of start during a conversion is ignored
    @(negedge clk);
    bin   = 14'd3875;
    start = 1'b1;
    push_exp(16'h3875, 1'b0);
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    bin = 14'd42;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40);
    repeat (40) @(negedge clk);
    check("v4_done_count", 32'(done_cnt - d0), 32'd1);
    check("v4_bcd_held", 32'(bcd), 32'h3875);

    // V5: reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bin   = 14'd5555;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("v5_rst_bcd",  32'(bcd),  32'd0);
    check("v5_rst_busy", 32'(busy), 32'd0);
    check("v5_rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    conv(14'd5555, 16'h5555, 1'b0);

    // V6: start held high gives back-to-back conversions
    @(negedge clk);
    bin   = 14'd1;
    start = 1'b1;
    push_exp(16'h0001, 1'b0);
    push_exp(16'h0002, 1'b0);
    push_exp(16'h0003, 1'b0);
    @(posedge clk);
    #1 bin = 14'd2;
    wait_done(40);
    t1 = cyc;
    repeat (2) @(posedge clk);
    #1 bin = 14'd3;
    wait_done(40);
    t2 = cyc;
    check("v6_period_1", 32'(t2 - t1), 32'd16);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(40);
    t3 = cyc;
    check("v6_period_2", 32'(t3 - t2), 32'd16);
    check("v6_last_bcd", 32'(bcd), 32'h0003);

    repeat (30) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
